// File: rtl/reg_write_sched_pkg.sv
// rtl/reg_write_sched_pkg.sv - shared widths and FSM encodings for the register-file write scheduler
package reg_write_sched_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int ADDR_W_DEF   = 3;
    localparam int NUM_REGS_DEF = 8;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

endpackage

// File: rtl/reg_write_sched_rr_arb2.sv
// rtl/reg_write_sched_rr_arb2.sv - two-way round-robin arbiter owning the rotating priority pointer
module reg_write_sched_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    input  logic       en_i,
    output logic [1:0] grant_o
);

    logic rr_ptr_q;
    logic rr_ptr_d;

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = rr_ptr_q ? 2'b10 : 2'b01;
                default: grant_o = 2'b00;
            endcase
        end
    end

    // Priority moves to the requester that was not just served.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_o[0]) begin
            rr_ptr_d = 1'b1;
        end else if (grant_o[1]) begin
            rr_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/reg_write_sched.sv
// rtl/reg_write_sched.sv - shares the reg_file write port between two requesters and a hardware clear walk
module reg_write_sched
    import reg_write_sched_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                NUM_REGS  = NUM_REGS_DEF,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_inaddr,
    output logic [DATA_W-1:0] rf_in
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    logic [0:0]        state_q,     state_d;
    logic [ADDR_W-1:0] clr_cnt_q,   clr_cnt_d;
    logic              rf_we_q,     rf_we_d;
    logic [ADDR_W-1:0] rf_inaddr_q, rf_inaddr_d;
    logic [DATA_W-1:0] rf_in_q,     rf_in_d;

    logic       arb_en;
    logic [1:0] grant;

    // A pending clear request blocks arbitration in the same cycle it is seen.
    assign arb_en = RESET && (state_q == S_IDLE) && !clr_req;

    reg_write_sched_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (RESET),
        .valid_i ({req1_valid, req0_valid}),
        .en_i    (arb_en),
        .grant_o (grant)
    );

    assign req0_ready = grant[0] && RESET;
    assign req1_ready = grant[1] && RESET;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rf_we_d     = 1'b0;
        rf_inaddr_d = rf_inaddr_q;
        rf_in_d     = rf_in_q;
        if (state_q == S_CLEAR) begin
            rf_we_d     = 1'b1;
            rf_inaddr_d = clr_cnt_q;
            rf_in_d     = CLEAR_VAL;
            if (clr_cnt_q == LAST_ADDR) begin
                clr_cnt_d = '0;
                state_d   = S_IDLE;
            end else begin
                clr_cnt_d = clr_cnt_q + 1'b1;
            end
        end else if (clr_req) begin
            state_d   = S_CLEAR;
            clr_cnt_d = '0;
        end else if (grant[0]) begin
            rf_we_d     = 1'b1;
            rf_inaddr_d = req0_addr;
            rf_in_d     = req0_data;
        end else if (grant[1]) begin
            rf_we_d     = 1'b1;
            rf_inaddr_d = req1_addr;
            rf_in_d     = req1_data;
        end
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            clr_cnt_q   <= '0;
            rf_we_q     <= 1'b0;
            rf_inaddr_q <= '0;
            rf_in_q     <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rf_we_q     <= rf_we_d;
            rf_inaddr_q <= rf_inaddr_d;
            rf_in_q     <= rf_in_d;
        end
    end

    assign clr_busy  = (state_q == S_CLEAR);
    assign rf_we     = rf_we_q;
    assign rf_inaddr = rf_inaddr_q;
    assign rf_in     = rf_in_q;

endmodule

// File: tb/tb_reg_write_sched.sv
// tb/tb_reg_write_sched.sv - directed and random checks of reg_write_sched against a behavioural model
module tb_reg_write_sched;

    logic       clk;
    logic       RESET;
    logic       req0_valid, req1_valid;
    logic [2:0] req0_addr,  req1_addr;
    logic [7:0] req0_data,  req1_data;
    logic       req0_ready, req1_ready;
    logic       clr_req;
    logic       clr_busy;
    logic       rf_we;
    logic [2:0] rf_inaddr;
    logic [7:0] rf_in;

    int total = 0;
    int bad   = 0;

    logic [7:0] rf_mem   [8] = '{default: 8'h00};
    logic [7:0] exp_regs [8] = '{default: 8'h00};

    // Reference model: clear is a list of addresses still to be written, arbitration remembers the last winner.
    bit         m_clearing;
    int         m_clr_idx;
    bit         m_last;
    logic       m_we;
    logic [2:0] m_addr;
    logic [7:0] m_data;

    reg_write_sched dut (
        .clk        (clk),
        .RESET      (RESET),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .rf_we      (rf_we),
        .rf_inaddr  (rf_inaddr),
        .rf_in      (rf_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rf_we) rf_mem[rf_inaddr] <= rf_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("reg%0d", i), 32'(rf_mem[i]), 32'(exp_regs[i]));
        end
    endtask

    task automatic model_reset();
        m_clearing = 1'b0;
        m_clr_idx  = 0;
        m_last     = 1'b1;
        m_we       = 1'b0;
        m_addr     = 3'd0;
        m_data     = 8'd0;
    endtask

    // Called just after a posedge; returns just after the following posedge.
    task automatic step(input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                        input logic v1, input logic [2:0] a1, input logic [7:0] d1,
                        input logic cr);
        bit g0, g1;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        clr_req    = cr;
        #1;
        chk("rf_we",     32'(rf_we),     32'(m_we));
        chk("rf_inaddr", 32'(rf_inaddr), 32'(m_addr));
        chk("rf_in",     32'(rf_in),     32'(m_data));
        chk("clr_busy",  32'(clr_busy),  32'(m_clearing));
        if (m_we) exp_regs[m_addr] = m_data;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!m_clearing && !cr) begin
            if (v0 && v1) begin
                if (m_last) g0 = 1'b1;
                else        g1 = 1'b1;
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        chk("req0_ready", 32'(req0_ready), 32'(g0));
        chk("req1_ready", 32'(req1_ready), 32'(g1));
        if (m_clearing) begin
            m_we   = 1'b1;
            m_addr = 3'(m_clr_idx);
            m_data = 8'h00;
            m_clr_idx++;
            if (m_clr_idx == 8) m_clearing = 1'b0;
        end else if (cr) begin
            m_clearing = 1'b1;
            m_clr_idx  = 0;
            m_we       = 1'b0;
        end else if (g0) begin
            m_we = 1'b1; m_addr = a0; m_data = d0; m_last = 1'b0;
        end else if (g1) begin
            m_we = 1'b1; m_addr = a1; m_data = d1; m_last = 1'b1;
        end else begin
            m_we = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse(input int ncyc);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        clr_req    = 1'b0;
        RESET      = 1'b0;
        #1;
        chk("rst_rf_we",     32'(rf_we),      32'd0);
        chk("rst_rf_inaddr", 32'(rf_inaddr),  32'd0);
        chk("rst_rf_in",     32'(rf_in),      32'd0);
        chk("rst_clr_busy",  32'(clr_busy),   32'd0);
        chk("rst_ready0",    32'(req0_ready), 32'd0);
        chk("rst_ready1",    32'(req1_ready), 32'd0);
        model_reset();
        repeat (ncyc) @(posedge clk);
        #1;
        RESET = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    initial begin
        RESET = 1'b1;
        req0_valid = 1'b0; req0_addr = 3'd0; req0_data = 8'h00;
        req1_valid = 1'b0; req1_addr = 3'd0; req1_data = 8'h00;
        clr_req = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_pulse(2);

        // single write
        step(1'b1, 3'd5, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b0);
        idle(1);
        chk("single_reg5", 32'(rf_mem[5]), 32'h0000_00FF);

        // contention
        repeat (4) step(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0);
        idle(1);
        chk_regs();

        // same address, requester 1 holds priority
        step(1'b1, 3'd3, 8'hAA, 1'b1, 3'd3, 8'hBB, 1'b0);
        step(1'b1, 3'd3, 8'hAA, 1'b0, 3'd0, 8'h00, 1'b0);
        idle(2);
        chk("same_addr_reg3", 32'(rf_mem[3]), 32'h0000_00AA);

        // clear while req0 waits
        for (int i = 1; i < 8; i++) step(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 8'(8'h10 + i), 1'b0);
        step(1'b1, 3'd0, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b1);
        repeat (10) step(1'b1, 3'd0, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b0);
        idle(2);
        chk_regs();
        chk("clear_reg0", 32'(rf_mem[0]), 32'h0000_005A);
        chk("clear_reg7", 32'(rf_mem[7]), 32'h0000_0000);

        // reset in the middle of a clear
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 8'(8'hC0 + i), 1'b0, 3'd0, 8'h00, 1'b0);
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1);
        idle(5);
        rst_pulse(2);
        idle(2);
        chk_regs();
        chk("midclr_reg3", 32'(rf_mem[3]), 32'h0000_0000);
        chk("midclr_reg4", 32'(rf_mem[4]), 32'h0000_00C4);

        // held clear request chains a second walk
        repeat (12) step(1'b1, 3'd6, 8'h66, 1'b0, 3'd0, 8'h00, 1'b1);
        repeat (10) step(1'b1, 3'd6, 8'h66, 1'b1, 3'd7, 8'h77, 1'b0);
        idle(2);
        chk_regs();

        // random traffic
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_pulse(int'($urandom_range(1, 2)));
            end else begin
                step(1'($urandom), 3'($urandom), 8'($urandom),
                     1'($urandom), 3'($urandom), 8'($urandom),
                     1'($urandom_range(0, 39) == 0));
            end
            if (n % 50 == 49) chk_regs();
        end
        idle(12);
        chk_regs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
